// File: rtl/st_less_than_array.sv
// Multi-channel gamma-cycle temporal less-than (inhibit) array with per-cycle fire count.
// Optional macro LT_LEQ_EN: a tie between a and b fires the channel (less-than-or-equal).
module st_less_than_array #(
  parameter int NUM_CH            = 4,
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH       = 8
) (
  input  logic                          aclk,
  input  logic                          grst,
  input  logic                          set,
  input  logic [NUM_CH-1:0]             a,
  input  logic [NUM_CH-1:0]             b,
  output logic [NUM_CH-1:0]             q,
  output logic                          gamma_start,
  output logic [$clog2(NUM_CH+1)-1:0]   fire_count
);

  localparam int GW  = (GAMMA_CYCLE_WIDTH > 1) ? $clog2(GAMMA_CYCLE_WIDTH) : 1;
  localparam int PCW = $clog2(PULSE_WIDTH) + 1;
  localparam int FW  = $clog2(NUM_CH + 1);

  typedef enum logic [1:0] {
    ST_ARMED     = 2'd0,
    ST_INHIBITED = 2'd1,
    ST_FIRE      = 2'd2,
    ST_SPENT     = 2'd3
  } ch_state_t;

  logic [GW-1:0]     gcnt_q, gcnt_d;
  logic              gamma_start_q, gamma_start_d;
  logic [FW-1:0]     fire_count_q, fire_count_d;
  logic [NUM_CH-1:0] q_q, q_d;
  ch_state_t         state_q [NUM_CH];
  ch_state_t         state_d [NUM_CH];
  logic [PCW-1:0]    pcnt_q  [NUM_CH];
  logic [PCW-1:0]    pcnt_d  [NUM_CH];

  logic              boundary_s;
  logic [FW-1:0]     fired_cnt_s;

  // Next-state logic: gamma counter, per-channel comparator FSMs and closing fire count.
  always_comb begin
    gcnt_d        = gcnt_q;
    gamma_start_d = gamma_start_q;
    fire_count_d  = fire_count_q;
    q_d           = q_q;
    state_d       = state_q;
    pcnt_d        = pcnt_q;

    boundary_s  = set || (gcnt_q == GW'(GAMMA_CYCLE_WIDTH - 1));

    // A channel has fired this cycle once it has left ARMED through FIRE (still pulsing or spent).
    fired_cnt_s = {FW{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      fired_cnt_s = fired_cnt_s + FW'((state_q[i] == ST_FIRE) || (state_q[i] == ST_SPENT));
    end

    if (boundary_s) begin
      gcnt_d        = {GW{1'b0}};
      gamma_start_d = 1'b1;
      fire_count_d  = fired_cnt_s;
      q_d           = {NUM_CH{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
        state_d[i] = ST_ARMED;
        pcnt_d[i]  = {PCW{1'b0}};
      end
    end else begin
      gcnt_d        = gcnt_q + GW'(1);
      gamma_start_d = 1'b0;
      fire_count_d  = fire_count_q;
      for (int i = 0; i < NUM_CH; i++) begin
        case (state_q[i])
          ST_ARMED: begin
`ifdef LT_LEQ_EN
            if (a[i]) begin
              state_d[i] = ST_FIRE;
              pcnt_d[i]  = PCW'(1);
              q_d[i]     = 1'b1;
            end else if (b[i]) begin
              state_d[i] = ST_INHIBITED;
              q_d[i]     = 1'b0;
            end else begin
              state_d[i] = ST_ARMED;
              q_d[i]     = 1'b0;
            end
`else
            if (b[i]) begin
              state_d[i] = ST_INHIBITED;
              q_d[i]     = 1'b0;
            end else if (a[i]) begin
              state_d[i] = ST_FIRE;
              pcnt_d[i]  = PCW'(1);
              q_d[i]     = 1'b1;
            end else begin
              state_d[i] = ST_ARMED;
              q_d[i]     = 1'b0;
            end
`endif
          end
          ST_FIRE: begin
            if (pcnt_q[i] == PCW'(PULSE_WIDTH)) begin
              state_d[i] = ST_SPENT;
              q_d[i]     = 1'b0;
            end else begin
              pcnt_d[i]  = pcnt_q[i] + PCW'(1);
              q_d[i]     = 1'b1;
            end
          end
          ST_INHIBITED, ST_SPENT: begin
            q_d[i] = 1'b0;
          end
          default: begin
            state_d[i] = ST_ARMED;
            pcnt_d[i]  = {PCW{1'b0}};
            q_d[i]     = 1'b0;
          end
        endcase
      end
    end
  end

  // State and output registers; reset lands in slot 0 with every channel armed.
  always_ff @(posedge aclk or posedge grst) begin
    if (grst) begin
      gcnt_q        <= {GW{1'b0}};
      gamma_start_q <= 1'b1;
      fire_count_q  <= {FW{1'b0}};
      q_q           <= {NUM_CH{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= ST_ARMED;
        pcnt_q[i]  <= {PCW{1'b0}};
      end
    end else begin
      gcnt_q        <= gcnt_d;
      gamma_start_q <= gamma_start_d;
      fire_count_q  <= fire_count_d;
      q_q           <= q_d;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        pcnt_q[i]  <= pcnt_d[i];
      end
    end
  end

  assign q           = q_q;
  assign gamma_start = gamma_start_q;
  assign fire_count  = fire_count_q;

endmodule

// File: doc/st_less_than_array.md
Name: st_less_than_array

Overview:
- Multi-channel, gamma-cycle-aware temporal "less-than" (inhibit) primitive for the space-time computing datapath.
- Each of NUM_CH channels passes its a-event as a fixed-width output pulse only if a arrives strictly before its inhibit b within the current gamma cycle.
- Owns the gamma-cycle counter, re-arms all channels at each gamma boundary, and reports the per-cycle fire count to downstream WTA/readout logic.

Parameters:
- NUM_CH, 4, number of independent comparator channels (>=1).
- GAMMA_CYCLE_WIDTH, 16, gamma cycle length in aclk cycles (>=2).
- PULSE_WIDTH, 8, output pulse length in aclk cycles (1 <= PULSE_WIDTH < GAMMA_CYCLE_WIDTH).

Ports:
- aclk  in  1  clock.
- grst  in  1  asynchronous active-high reset.
- set  in  1  synchronous gamma restart; forces new gamma cycle.
- a  in  NUM_CH  per-channel data event (step-coded; first sampled 1 = arrival).
- b  in  NUM_CH  per-channel inhibit event (step-coded).
- q  out  NUM_CH  per-channel pulse-width-coded result.
- gamma_start  out  1  high during slot 0 of each gamma cycle.
- fire_count  out  $clog2(NUM_CH+1)  channels fired in the previous completed gamma cycle.

Behaviour:
- All inputs sampled on posedge aclk. All outputs registered.
- Reset: gcnt=0, all channels ARMED, q=0, fire_count=0, gamma_start=1 (slot 0). Reset mid-pulse truncates immediately.
- Gamma counter gcnt, width $clog2(GAMMA_CYCLE_WIDTH), counts 0..GAMMA_CYCLE_WIDTH-1 and wraps to 0. gamma_start = (gcnt==0).
- Boundary edge: the edge where gcnt==GAMMA_CYCLE_WIDTH-1, or set==1.
  - gcnt<=0, every channel ->ARMED, q<=0, pulse counters cleared.
  - fire_count<= number of channels that entered FIRE this gamma cycle, including any pulse truncated here.
  - a/b sampled on the boundary edge are ignored.
- set while gcnt==0 restarts again. It does not double-count: the closing count is that of the cycle just ended (0 if nothing fired).
- Per-channel FSM on non-boundary edges:
  - ARMED: b=1 -> INHIBITED (regardless of a). a=1 and b=0 -> FIRE, with q=1 from the next cycle and pcnt=1. Otherwise stay.
  - FIRE: q held 1 for exactly PULSE_WIDTH cycles (pcnt 1..PULSE_WIDTH), then -> SPENT with q=0. b arriving during FIRE has no effect. a deasserting has no effect.
  - INHIBITED, SPENT: q=0. Hold until the boundary. No re-fire within the same gamma cycle.
- Latency: a sampled at edge k -> q high after edge k, through edge k+PULSE_WIDTH.
- Tie (a and b first sampled on the same edge): INHIBITED. Strict less-than.
- A pulse that would cross the gamma boundary is truncated at the boundary edge.
- Channels are fully independent. Multiple channels may fire on the same edge.
- fire_count is held constant for the whole following gamma cycle.
- Width rule: pcnt width $clog2(PULSE_WIDTH)+1 and saturates at PULSE_WIDTH. fire_count cannot overflow (max NUM_CH).

Optional Feature:
- Macro LT_LEQ_EN.
- Defined: tie case (a and b first sampled on the same edge, channel ARMED) -> FIRE, giving less-than-or-equal semantics. b strictly earlier still -> INHIBITED.
- Undefined: tie -> INHIBITED (strict less-than, default).
- All other behaviour is identical.

Test Plan (defaults NUM_CH=4, GAMMA_CYCLE_WIDTH=16, PULSE_WIDTH=8):
- Reset release, a=b=0 for 32 cycles -> q=0; gamma_start high at gcnt 0 only (every 16 cycles); fire_count=0.
- ch0: a=1 at slot 3, b=1 at slot 6 -> q[0] high slots 4..11 (exactly 8 cycles); next cycle fire_count=1.
- ch1: b at slot 2, a at slot 5 -> q[1] stays 0. ch2: a and b both at slot 4 -> q[2]=0 without LT_LEQ_EN; q[2] high slots 5..12 with it.
- ch3: a at slot 12 -> q[3] high slots 13..15, then cleared at the boundary (3 cycles); fire_count=1 for the following cycle. a held high across the boundary -> re-fires at slot 1 of the new cycle.
- All 4 channels: a at slot 1, b=0 -> all q high slots 2..9; next cycle fire_count=4.
- set pulsed at slot 7 while ch0 is in FIRE -> q[0] drops, gcnt=0 next cycle, gamma_start=1, fire_count=1. grst asserted mid-pulse -> q=0 and fire_count=0 immediately (asynchronous).
